// File: rtl/add_pipe_nb.sv
// Pipelined WIDTH-bit adder/subtractor with valid/ready handshake and full backpressure.
// Each of STAGES stages adds one CH-bit chunk and hands its carry to the next stage.
module add_pipe_nb #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned Ch   = WIDTH / STAGES;
  localparam int unsigned Last = STAGES - 1;

  // Per-stage state: operands travel along so later stages can pick up their chunk.
  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] carry_q;
  logic [WIDTH-1:0]  a_q   [STAGES];
  logic [WIDTH-1:0]  b_q   [STAGES];
  logic [WIDTH-1:0]  sum_q [STAGES];
  logic              ovf_q;

  logic [STAGES:0]   adv;
  logic [STAGES-1:0] src_valid;
  logic [STAGES-1:0] src_carry;
  logic [STAGES-1:0] carry_d;
  logic [WIDTH-1:0]  src_a   [STAGES];
  logic [WIDTH-1:0]  src_b   [STAGES];
  logic [WIDTH-1:0]  src_sum [STAGES];
  logic [WIDTH-1:0]  sum_d   [STAGES];
  logic              ovf_d;

  // A stage may load when it is empty or its successor is moving.
  always_comb begin
    adv         = '0;
    adv[STAGES] = out_ready;
    for (int unsigned k = STAGES; k > 0; k--) begin
      adv[k-1] = !valid_q[k-1] || adv[k];
    end
  end

  assign in_ready = adv[0];

  always_comb begin
    src_valid[0] = in_valid;
    src_a[0]     = a;
    src_b[0]     = sub ? ~b : b;
    src_carry[0] = sub | cin;
    src_sum[0]   = '0;
    for (int unsigned k = 1; k < STAGES; k++) begin
      src_valid[k] = valid_q[k-1];
      src_a[k]     = a_q[k-1];
      src_b[k]     = b_q[k-1];
      src_carry[k] = carry_q[k-1];
      src_sum[k]   = sum_q[k-1];
    end
  end

  always_comb begin
    logic [Ch:0] part;
    part = '0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      part = {1'b0, src_a[k][k*Ch +: Ch]} + {1'b0, src_b[k][k*Ch +: Ch]}
           + {{Ch{1'b0}}, src_carry[k]};
      sum_d[k]              = src_sum[k];
      sum_d[k][k*Ch +: Ch]  = part[Ch-1:0];
      carry_d[k]            = part[Ch];
    end
    ovf_d = (src_a[Last][WIDTH-1] == src_b[Last][WIDTH-1]) &&
            (sum_d[Last][WIDTH-1] != src_a[Last][WIDTH-1]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      carry_q <= '0;
      ovf_q   <= 1'b0;
      for (int unsigned k = 0; k < STAGES; k++) begin
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        sum_q[k] <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        if (adv[k]) begin
          valid_q[k] <= src_valid[k];
          // Bubbles leave the data registers untouched.
          if (src_valid[k]) begin
            a_q[k]     <= src_a[k];
            b_q[k]     <= src_b[k];
            sum_q[k]   <= sum_d[k];
            carry_q[k] <= carry_d[k];
          end
        end
      end
      if (adv[Last] && src_valid[Last]) begin
        ovf_q <= ovf_d;
      end
    end
  end

  assign out_valid = valid_q[Last];
  assign sum       = sum_q[Last];
  assign cout      = carry_q[Last];
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_add_pipe_nb.sv
// Directed and scoreboard bench for add_pipe_nb: vector table on an 8-bit/2-stage instance,
// hand sequences for backpressure and reset, random streams on 1-, 4-stage and 16-bit builds.
module tb_add_pipe_nb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid, cin, sub, out_ready;
  logic [15:0] a16, b16;
  logic [3:0]  rdy, ovl, co, of;
  logic [7:0]  s0, s1, s2;
  logic [15:0] s3;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit sb_en = 1'b0;
  logic [17:0] q0[$], q1[$], q2[$], q3[$];
  int cnt[4], first_c[4], last_c[4];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  add_pipe_nb #(.WIDTH(8), .STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[0]), .a(a16[7:0]),
    .b(b16[7:0]), .cin(cin), .sub(sub), .out_valid(ovl[0]), .out_ready(out_ready),
    .sum(s0), .cout(co[0]), .ovf(of[0]));
  add_pipe_nb #(.WIDTH(8), .STAGES(1)) u_s1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[1]), .a(a16[7:0]),
    .b(b16[7:0]), .cin(cin), .sub(sub), .out_valid(ovl[1]), .out_ready(out_ready),
    .sum(s1), .cout(co[1]), .ovf(of[1]));
  add_pipe_nb #(.WIDTH(8), .STAGES(4)) u_s4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[2]), .a(a16[7:0]),
    .b(b16[7:0]), .cin(cin), .sub(sub), .out_valid(ovl[2]), .out_ready(out_ready),
    .sum(s2), .cout(co[2]), .ovf(of[2]));
  add_pipe_nb #(.WIDTH(16), .STAGES(4)) u_w16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[3]), .a(a16),
    .b(b16), .cin(cin), .sub(sub), .out_valid(ovl[3]), .out_ready(out_ready),
    .sum(s3), .cout(co[3]), .ovf(of[3]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Plain full-width reference: returns {ovf, cout, sum[15:0]}.
  function automatic logic [17:0] model(input int w, input logic [15:0] aa, input logic [15:0] bb,
                                        input logic ci, input logic sb);
    logic [16:0] mask, ax, bx, r, s;
    logic        c, o;
    mask = (17'd1 << w) - 17'd1;
    ax   = {1'b0, aa} & mask;
    bx   = (sb ? ~{1'b0, bb} : {1'b0, bb}) & mask;
    r    = ax + bx + ((sb || ci) ? 17'd1 : 17'd0);
    s    = r & mask;
    c    = r[w];
    o    = (ax[w-1] == bx[w-1]) && (s[w-1] != ax[w-1]);
    return {o, c, s[15:0]};
  endfunction

  task automatic sb_pop(input int id, input logic [17:0] got);
    logic [17:0] exp;
    int sz;
    case (id)
      0: sz = q0.size();
      1: sz = q1.size();
      2: sz = q2.size();
      default: sz = q3.size();
    endcase
    if (sz == 0) begin
      chk($sformatf("tput%0d spurious result", id), 32'(got), 32'h3ffff);
    end else begin
      case (id)
        0: exp = q0.pop_front();
        1: exp = q1.pop_front();
        2: exp = q2.pop_front();
        default: exp = q3.pop_front();
      endcase
      chk($sformatf("tput%0d result %0d", id, cnt[id]), 32'(got), 32'(exp));
      if (cnt[id] == 0) first_c[id] = cyc;
      last_c[id] = cyc;
      cnt[id]++;
    end
  endtask

  // Sampled at negedge: outputs are settled, and any push here transfers at the next posedge.
  always @(negedge clk) begin
    if (sb_en) begin
      if (ovl[0]) sb_pop(0, {of[0], co[0], 8'h00, s0});
      if (ovl[1]) sb_pop(1, {of[1], co[1], 8'h00, s1});
      if (ovl[2]) sb_pop(2, {of[2], co[2], 8'h00, s2});
      if (ovl[3]) sb_pop(3, {of[3], co[3], s3});
      if (in_valid) begin
        if (rdy[0]) q0.push_back(model(8, a16, b16, cin, sub));
        if (rdy[1]) q1.push_back(model(8, a16, b16, cin, sub));
        if (rdy[2]) q2.push_back(model(8, a16, b16, cin, sub));
        if (rdy[3]) q3.push_back(model(16, a16, b16, cin, sub));
      end
    end
  end

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic [7:0] s;
    logic       co;
    logic       of;
  } vec_t;

  vec_t vecs[10];

  initial begin
    vecs[0] = '{8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[3] = '{8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0};
    vecs[4] = '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0};
    vecs[5] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
    vecs[6] = '{8'h33, 8'h33, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[7] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[8] = '{8'h00, 8'h01, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};
    vecs[9] = '{8'h12, 8'h34, 1'b1, 1'b0, 8'h47, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      cnt[i] = 0;
      first_c[i] = 0;
      last_c[i] = 0;
    end

    // Reset with random activity on the inputs.
    in_valid = 1'b0; out_ready = 1'b0; cin = 1'b0; sub = 1'b0; a16 = '0; b16 = '0;
    repeat (3) begin
      @(posedge clk); #1;
      a16 = 16'($urandom); b16 = 16'($urandom);
      cin = 1'($urandom); sub = 1'($urandom);
      in_valid = 1'($urandom); out_ready = 1'($urandom);
    end
    chk("reset out_valid", 32'(ovl), 32'h0);
    chk("reset sum", 32'(s0), 32'h0);
    chk("reset cout", 32'(co[0]), 32'h0);
    chk("reset ovf", 32'(of[0]), 32'h0);
    #2;
    rst_n = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("in_ready after reset", 32'(rdy[0]), 32'h1);
    tick();

    // Directed vectors, one at a time, result one edge after acceptance.
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      a16 = {8'h00, vecs[i].a}; b16 = {8'h00, vecs[i].b};
      cin = vecs[i].cin; sub = vecs[i].sub;
      chk($sformatf("vec%0d in_ready", i), 32'(rdy[0]), 32'h1);
      tick();
      in_valid = 1'b0;
      chk($sformatf("vec%0d early valid", i), 32'(ovl[0]), 32'h0);
      tick();
      chk($sformatf("vec%0d out_valid", i), 32'(ovl[0]), 32'h1);
      chk($sformatf("vec%0d sum", i), 32'(s0), 32'(vecs[i].s));
      chk($sformatf("vec%0d cout", i), 32'(co[0]), 32'(vecs[i].co));
      chk($sformatf("vec%0d ovf", i), 32'(of[0]), 32'(vecs[i].of));
    end
    tick();
    repeat (5) tick();

    // Backpressure: two accepted, third refused, outputs hold, then drain in order.
    out_ready = 1'b0;
    in_valid = 1'b1; a16 = 16'h0010; b16 = 16'h0020; cin = 1'b0; sub = 1'b0;
    chk("bp in_ready A", 32'(rdy[0]), 32'h1);
    tick();
    a16 = 16'h00F0; b16 = 16'h0020;
    chk("bp in_ready B", 32'(rdy[0]), 32'h1);
    tick();
    a16 = 16'h0001; b16 = 16'h0002; sub = 1'b1;
    chk("bp in_ready full", 32'(rdy[0]), 32'h0);
    chk("bp out_valid A", 32'(ovl[0]), 32'h1);
    chk("bp sum A", 32'(s0), 32'h30);
    tick();
    chk("bp in_ready held", 32'(rdy[0]), 32'h0);
    chk("bp sum A stable", 32'(s0), 32'h30);
    chk("bp cout A stable", 32'(co[0]), 32'h0);
    out_ready = 1'b1;
    #1;
    chk("bp in_ready comb", 32'(rdy[0]), 32'h1);
    tick();
    in_valid = 1'b0;
    chk("bp out_valid B", 32'(ovl[0]), 32'h1);
    chk("bp sum B", 32'(s0), 32'h10);
    chk("bp cout B", 32'(co[0]), 32'h1);
    tick();
    chk("bp out_valid C", 32'(ovl[0]), 32'h1);
    chk("bp sum C", 32'(s0), 32'hFF);
    chk("bp cout C", 32'(co[0]), 32'h0);
    tick();
    chk("bp drained", 32'(ovl[0]), 32'h0);
    repeat (6) tick();

    // Back-to-back random stream on all builds.
    sb_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      a16 = 16'($urandom); b16 = 16'($urandom);
      cin = 1'($urandom); sub = 1'($urandom);
      tick();
    end
    in_valid = 1'b0;
    repeat (8) tick();
    sb_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("tput%0d count", i), 32'(cnt[i]), 32'd16);
      chk($sformatf("tput%0d consecutive", i), 32'(last_c[i] - first_c[i]), 32'd15);
    end

    // Reset while two results are in flight.
    out_ready = 1'b0;
    in_valid = 1'b1; a16 = 16'h0040; b16 = 16'h0005; cin = 1'b0; sub = 1'b0;
    tick();
    a16 = 16'h0011; b16 = 16'h0022;
    tick();
    in_valid = 1'b0;
    chk("mid out_valid before", 32'(ovl[0]), 32'h1);
    chk("mid sum before", 32'(s0), 32'h45);
    #3;
    rst_n = 1'b0;
    #1;
    chk("mid out_valid cleared", 32'(ovl), 32'h0);
    chk("mid sum cleared", 32'(s0), 32'h0);
    chk("mid cout cleared", 32'(co[0]), 32'h0);
    chk("mid ovf cleared", 32'(of[0]), 32'h0);
    #2;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("no stale result %0d", i), 32'(ovl), 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
